// File: rtl/branch_target_predictor_pkg.sv
// Shared constants for the branch target predictor and its helper mux.
package branch_target_predictor_pkg;

  localparam logic        HIGH            = 1'b1;
  localparam logic        LOW             = 1'b0;
  localparam int          DEFAULT_ENTRIES = 64;
  localparam int          ADDR_W          = 32;
  localparam logic [31:0] PC_INCREMENT    = 32'd4;

endpackage : branch_target_predictor_pkg

// File: rtl/branch_target_predictor_mux.sv
// Parameterized-width 2:1 combinational multiplexer (SELECT=0 -> IN1, SELECT=1 -> IN2).
module multiplexer_2_to_1
  import branch_target_predictor_pkg::*;
#(
  parameter int WIDTH = ADDR_W
) (
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic             SELECT,
  output logic [WIDTH-1:0] OUT
);

  // Route one of the two inputs to the output.
  always_comb begin
    OUT = IN1;
    if (SELECT == HIGH) begin
      OUT = IN2;
    end else begin
      OUT = IN1;
    end
  end

endmodule : multiplexer_2_to_1

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target predictor: combinational lookup of the fetch PC,
// single-cycle learning of resolved targets from the execute stage.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int ENTRIES    = DEFAULT_ENTRIES,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [ADDR_WIDTH-1:0] PC,
  input  logic [ADDR_WIDTH-1:0] PC_EXECUTION,
  input  logic [ADDR_WIDTH-1:0] PC_PREDICT_LEARN,
  input  logic                  PC_PREDICT_LEARN_SELECT,
  output logic [ADDR_WIDTH-1:0] PC_PREDICTED,
  output logic                  PC_PREDICTOR_STATUS
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = ADDR_WIDTH - IW - 2;

  logic [ENTRIES-1:0]                 valid_q, valid_d;
  logic [ENTRIES-1:0][TW-1:0]         tag_q, tag_d;
  logic [ENTRIES-1:0][ADDR_WIDTH-1:0] target_q, target_d;

  logic [IW-1:0]         rd_idx_s, wr_idx_s;
  logic [TW-1:0]         rd_tag_s, wr_tag_s;
  logic                  hit_s;
  logic [ADDR_WIDTH-1:0] pc_plus_inc_s;
  logic                  unused_low_bits_s;

  // Byte-offset bits never take part in indexing or tag matching.
  assign unused_low_bits_s = ^{PC[1:0], PC_EXECUTION[1:0]};

  assign rd_idx_s      = PC[IW+1:2];
  assign rd_tag_s      = PC[ADDR_WIDTH-1:IW+2];
  assign wr_idx_s      = PC_EXECUTION[IW+1:2];
  assign wr_tag_s      = PC_EXECUTION[ADDR_WIDTH-1:IW+2];
  assign pc_plus_inc_s = PC + ADDR_WIDTH'(PC_INCREMENT);

  // Next table contents: overwrite the indexed entry when learning, else hold.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (PC_PREDICT_LEARN_SELECT == HIGH) begin
      valid_d[wr_idx_s]  = HIGH;
      tag_d[wr_idx_s]    = wr_tag_s;
      target_d[wr_idx_s] = PC_PREDICT_LEARN;
    end else begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
    end
  end

  // Table storage; reset wipes every entry and masks any write in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  // Hit detection reads the registered table, so a same-index write shows up only after the edge.
  always_comb begin
    hit_s = LOW;
    if ((valid_q[rd_idx_s] == HIGH) && (tag_q[rd_idx_s] == rd_tag_s)) begin
      hit_s = HIGH;
    end else begin
      hit_s = LOW;
    end
  end

  assign PC_PREDICTOR_STATUS = hit_s;

  multiplexer_2_to_1 #(
    .WIDTH (ADDR_WIDTH)
  ) u_next_pc_mux (
    .IN1    (pc_plus_inc_s),
    .IN2    (target_q[rd_idx_s]),
    .SELECT (hit_s),
    .OUT    (PC_PREDICTED)
  );

endmodule : branch_target_predictor

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor (default 64 entries, 32-bit PC).
module tb_branch_target_predictor;

  logic        CLK;
  logic        RST_N;
  logic [31:0] PC;
  logic [31:0] PC_EXECUTION;
  logic [31:0] PC_PREDICT_LEARN;
  logic        PC_PREDICT_LEARN_SELECT;
  logic [31:0] PC_PREDICTED;
  logic        PC_PREDICTOR_STATUS;

  typedef struct {
    logic        st;
    logic [31:0] pd;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;

  // Reference table: 64 entries, index = pc[7:2], tag = pc[31:8].
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_tgt   [64];

  branch_target_predictor dut (
    .CLK                     (CLK),
    .RST_N                   (RST_N),
    .PC                      (PC),
    .PC_EXECUTION            (PC_EXECUTION),
    .PC_PREDICT_LEARN        (PC_PREDICT_LEARN),
    .PC_PREDICT_LEARN_SELECT (PC_PREDICT_LEARN_SELECT),
    .PC_PREDICTED            (PC_PREDICTED),
    .PC_PREDICTOR_STATUS     (PC_PREDICTOR_STATUS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 24'd0;
      m_tgt[i]   = 32'd0;
    end
  endfunction

  function automatic void model_write(input logic [31:0] pce, input logic [31:0] tgt);
    int idx;
    idx          = int'(pce[7:2]);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = pce[31:8];
    m_tgt[idx]   = tgt;
  endfunction

  function automatic logic [32:0] model_exp(input logic [31:0] pc);
    int idx;
    idx = int'(pc[7:2]);
    if (m_valid[idx] && (m_tag[idx] == pc[31:8])) return {1'b1, m_tgt[idx]};
    return {1'b0, pc + 32'd4};
  endfunction

  // Drive a lookup PC and queue the expected response.
  task automatic drive_exp(input logic [31:0] pc, input logic st, input logic [31:0] pd, input string nm);
    PC = pc;
    sb_q.push_back('{st: st, pd: pd, nm: nm});
  endtask

  // One learn pulse across a single rising edge; returns #1 after that edge.
  task automatic learn(input logic [31:0] pce, input logic [31:0] tgt);
    PC_EXECUTION            = pce;
    PC_PREDICT_LEARN        = tgt;
    PC_PREDICT_LEARN_SELECT = 1'b1;
    @(posedge CLK);
    if (RST_N) model_write(pce, tgt);
    #1;
    PC_PREDICT_LEARN_SELECT = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] pcs [3] = '{32'h0000_0100, 32'h0000_0040, 32'hFFFF_FFFC};
    logic [31:0] pds [3] = '{32'h0000_0104, 32'h0000_0044, 32'h0000_0000};
    // A write requested while reset is held must be dropped.
    PC_EXECUTION            = 32'h0000_0100;
    PC_PREDICT_LEARN        = 32'h0000_0400;
    PC_PREDICT_LEARN_SELECT = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    PC_PREDICT_LEARN_SELECT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_exp(pcs[i], 1'b0, pds[i], "reset_held");
      #1;
      e = sb_q.pop_front();
      n_cmp++;
      if ({PC_PREDICTOR_STATUS, PC_PREDICTED} !== {e.st, e.pd}) begin
        n_bad++;
        $display("FAIL %s pc=%h: got status=%0b pred=%h, want status=%0b pred=%h",
                 e.nm, PC, PC_PREDICTOR_STATUS, PC_PREDICTED, e.st, e.pd);
      end
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    drive_exp(32'h0000_0100, 1'b0, 32'h0000_0104, "after_reset");
    #1;
    e = sb_q.pop_front();
    n_cmp++;
    if ({PC_PREDICTOR_STATUS, PC_PREDICTED} !== {e.st, e.pd}) begin
      n_bad++;
      $display("FAIL %s pc=%h: got status=%0b pred=%h, want status=%0b pred=%h",
               e.nm, PC, PC_PREDICTOR_STATUS, PC_PREDICTED, e.st, e.pd);
    end
  endtask

  task automatic test_learn_alias();
    exp_t e;
    logic [31:0] pcs [6] = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0200,
                            32'h0000_0200, 32'h0000_0100, 32'h0000_0104};
    logic        sts [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] pds [6] = '{32'h0000_0400, 32'h0000_0108, 32'h0000_0204,
                            32'h0000_0800, 32'h0000_0104, 32'h0000_0108};
    learn(32'h0000_0100, 32'h0000_0400);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) learn(32'h0000_0200, 32'h0000_0800);
      drive_exp(pcs[i], sts[i], pds[i], (i < 3) ? "learn_first" : "alias_replace");
      #1;
      e = sb_q.pop_front();
      n_cmp++;
      if ({PC_PREDICTOR_STATUS, PC_PREDICTED} !== {e.st, e.pd}) begin
        n_bad++;
        $display("FAIL %s pc=%h: got status=%0b pred=%h, want status=%0b pred=%h",
                 e.nm, PC, PC_PREDICTOR_STATUS, PC_PREDICTED, e.st, e.pd);
      end
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    PC                      = 32'h0000_0040;
    PC_EXECUTION            = 32'h0000_0040;
    PC_PREDICT_LEARN        = 32'h0000_0080;
    PC_PREDICT_LEARN_SELECT = 1'b1;
    drive_exp(32'h0000_0040, 1'b0, 32'h0000_0044, "rdw_before_edge");
    #1;
    e = sb_q.pop_front();
    n_cmp++;
    if ({PC_PREDICTOR_STATUS, PC_PREDICTED} !== {e.st, e.pd}) begin
      n_bad++;
      $display("FAIL %s pc=%h: got status=%0b pred=%h, want status=%0b pred=%h",
               e.nm, PC, PC_PREDICTOR_STATUS, PC_PREDICTED, e.st, e.pd);
    end
    @(posedge CLK);
    model_write(32'h0000_0040, 32'h0000_0080);
    #1;
    PC_PREDICT_LEARN_SELECT = 1'b0;
    drive_exp(32'h0000_0040, 1'b1, 32'h0000_0080, "rdw_after_edge");
    #1;
    e = sb_q.pop_front();
    n_cmp++;
    if ({PC_PREDICTOR_STATUS, PC_PREDICTED} !== {e.st, e.pd}) begin
      n_bad++;
      $display("FAIL %s pc=%h: got status=%0b pred=%h, want status=%0b pred=%h",
               e.nm, PC, PC_PREDICTOR_STATUS, PC_PREDICTED, e.st, e.pd);
    end
  endtask

  task automatic test_wrap_and_hold();
    exp_t e;
    logic [31:0] pcs [4] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0200, 32'h0000_030C};
    logic        sts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] pds [4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0800, 32'h0000_0ABE};
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        // Learn inputs presented with select low: table must not change.
        PC_EXECUTION            = 32'hFFFF_FFFC;
        PC_PREDICT_LEARN        = 32'h0000_1234;
        PC_PREDICT_LEARN_SELECT = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
      end
      if (i == 3) learn(32'h0000_030C, 32'h0000_0ABE);
      drive_exp(pcs[i], sts[i], pds[i], "wrap_hold_unaligned");
      #1;
      e = sb_q.pop_front();
      n_cmp++;
      if ({PC_PREDICTOR_STATUS, PC_PREDICTED} !== {e.st, e.pd}) begin
        n_bad++;
        $display("FAIL %s pc=%h: got status=%0b pred=%h, want status=%0b pred=%h",
                 e.nm, PC, PC_PREDICTOR_STATUS, PC_PREDICTED, e.st, e.pd);
      end
    end
  endtask

  task automatic test_random();
    exp_t        e;
    logic [32:0] m;
    logic [31:0] pc;
    for (int i = 0; i < 40; i++) begin
      pc = {22'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 0) learn(pc, $urandom);
      pc = {22'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      m  = model_exp(pc);
      drive_exp(pc, m[32], m[31:0], "random_lookup");
      #1;
      e = sb_q.pop_front();
      n_cmp++;
      if ({PC_PREDICTOR_STATUS, PC_PREDICTED} !== {e.st, e.pd}) begin
        n_bad++;
        $display("FAIL %s pc=%h: got status=%0b pred=%h, want status=%0b pred=%h",
                 e.nm, PC, PC_PREDICTOR_STATUS, PC_PREDICTED, e.st, e.pd);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    logic [31:0] pcs [4] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0040, 32'h0000_030C};
    logic        sts [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] pds [4] = '{32'h0000_0400, 32'h0000_0104, 32'h0000_0044, 32'h0000_0310};
    learn(32'h0000_0100, 32'h0000_0400);
    learn(32'h0000_0040, 32'h0000_0080);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        model_clear();
      end
      if (i == 2) begin
        // Attempted write while reset is low, then release between edges.
        PC_EXECUTION            = 32'h0000_0040;
        PC_PREDICT_LEARN        = 32'h0000_0999;
        PC_PREDICT_LEARN_SELECT = 1'b1;
        @(posedge CLK);
        #2;
        PC_PREDICT_LEARN_SELECT = 1'b0;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
      end
      drive_exp(pcs[i], sts[i], pds[i], (i == 1) ? "reset_immediate" : "mid_reset");
      #1;
      e = sb_q.pop_front();
      n_cmp++;
      if ({PC_PREDICTOR_STATUS, PC_PREDICTED} !== {e.st, e.pd}) begin
        n_bad++;
        $display("FAIL %s pc=%h: got status=%0b pred=%h, want status=%0b pred=%h",
                 e.nm, PC, PC_PREDICTOR_STATUS, PC_PREDICTED, e.st, e.pd);
      end
    end
  endtask

  initial begin
    n_cmp                   = 0;
    n_bad                   = 0;
    RST_N                   = 1'b0;
    PC                      = 32'd0;
    PC_EXECUTION            = 32'd0;
    PC_PREDICT_LEARN        = 32'd0;
    PC_PREDICT_LEARN_SELECT = 1'b0;
    model_clear();
    #2;
    test_reset();
    test_learn_alias();
    test_same_cycle();
    test_wrap_and_hold();
    test_random();
    test_mid_reset();
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_branch_target_predictor

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter ENTRIES, default 64, SHALL be the number of predictor table entries; legal values are powers of two, at least 2.
REQ-003 Parameter ADDR_WIDTH, default 32, SHALL be the PC width.
REQ-004 Port CLK, input, 1 bit: the clock; all state updates occur on its rising edge.
REQ-005 Port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-006 Port PC, input, 32 bits: the fetch-stage PC to look up.
REQ-007 Port PC_EXECUTION, input, 32 bits: the PC of the control-transfer instruction being resolved in execute.
REQ-008 Port PC_PREDICT_LEARN, input, 32 bits: the resolved target to store for PC_EXECUTION.
REQ-009 Port PC_PREDICT_LEARN_SELECT, input, 1 bit: when high, write (learn) this cycle.
REQ-010 Port PC_PREDICTED, output, 32 bits: the predicted next PC.
REQ-011 Port PC_PREDICTOR_STATUS, output, 1 bit: high when PC hits a valid entry.

Function
REQ-012 The table SHALL be direct-mapped with ENTRIES entries; each entry holds a valid bit, a tag and a 32-bit target.
REQ-013 The index SHALL be address bits [IW+1:2], where IW = log2(ENTRIES); the tag SHALL be bits [31:IW+2]; bits [1:0] SHALL be ignored.
REQ-014 Lookup SHALL be purely combinational from PC: a hit is the valid bit of entry index(PC) set AND its stored tag equal to tag(PC).
REQ-015 PC_PREDICTOR_STATUS SHALL equal the hit flag, with zero cycles of latency.
REQ-016 On a hit, PC_PREDICTED SHALL be the stored target; on a miss it SHALL be PC+4, with modulo 2^32 wrap-around (0xFFFFFFFC gives 0x00000000).
REQ-017 When PC_PREDICT_LEARN_SELECT is high at a rising CLK edge, entry index(PC_EXECUTION) SHALL be set valid, given tag(PC_EXECUTION) and given target PC_PREDICT_LEARN, unconditionally overwriting any previous occupant.
REQ-018 When PC_PREDICT_LEARN_SELECT is low, the table SHALL be unchanged.
REQ-019 Read during write to the same index SHALL return the old contents until the edge; the new contents SHALL be visible combinationally immediately after the edge.
REQ-020 The block SHALL have no stall or flush input; learning is never blocked.
REQ-021 PC_PREDICT_LEARN SHALL be stored unmodified, including unaligned values.

Reset
REQ-022 While RST_N is low, all valid bits, tags and targets SHALL be cleared to 0 asynchronously, and a write requested in that cycle SHALL be ignored.
REQ-023 During and after reset, PC_PREDICTOR_STATUS SHALL be 0 and PC_PREDICTED SHALL be PC+4.
REQ-024 Reset asserted in mid-operation SHALL discard all learned entries.

Structure
REQ-025 A shared package SHALL hold HIGH/LOW (1'b1/1'b0), the default ENTRIES value, the 32-bit address width and the PC increment of 4.
REQ-026 One sub-module, multiplexer_2_to_1, SHALL be used: a parameterized-width combinational mux with inputs IN1 and IN2, input SELECT and output OUT, where SELECT=0 gives IN1 and SELECT=1 gives IN2.
REQ-027 multiplexer_2_to_1 SHALL have a default width of 32 and SHALL select PC_PREDICTED, with IN1 = PC+4, IN2 = the stored target and SELECT = hit.

Verification
REQ-028 Reset, then PC=0x00000100 -> STATUS=0, PREDICTED=0x00000104.
REQ-029 Learn PC_EXECUTION=0x00000100, target 0x00000400 at one edge, then PC=0x00000100 -> STATUS=1, PREDICTED=0x00000400; PC=0x00000104 -> STATUS=0, PREDICTED=0x00000108.
REQ-030 Alias test: after REQ-029, PC=0x00000200 (same index, different tag) -> STATUS=0, PREDICTED=0x00000204; then learn 0x00000200 with target 0x00000800 -> 0x00000200 hits with 0x00000800, and 0x00000100 now misses.
REQ-031 Same-cycle read/write: PC=PC_EXECUTION=0x00000040, learn target 0x00000080 -> STATUS=0 before the edge; STATUS=1 and PREDICTED=0x00000080 after the edge.
REQ-032 Wrap: PC=0xFFFFFFFC with no entry -> PREDICTED=0x00000000; learning with PC_PREDICT_LEARN_SELECT=0 -> no change.
REQ-033 Mid-run reset: pulse RST_N low asynchronously between edges after learning -> STATUS drops to 0 immediately, and all lookups miss afterwards.
